// File: rtl/weight_stream_receiver.sv
// weight_stream_receiver: AXI-Stream weight burst receiver into a local weight buffer with registered read port
module weight_stream_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [15:0]           cfg_addr,
  input  logic [15:0]           cfg_length,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           weights_received,
  output logic                  error,
  output logic [1:0]            err_code
);
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DRAIN, RX_DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [15:0] last_idx;
  logic [16:0] cfg_end;
  logic cfg_ok, beat, at_last, wr;
  assign cfg_end = {1'b0, cfg_addr} + {1'b0, cfg_length};
  assign cfg_ok = cfg_length != 16'd0 && cfg_end <= 17'(DEPTH);
  assign cfg_ready = state == RX_IDLE;
  assign s_tready = state == RX_RECV || state == RX_DRAIN;
  assign busy = s_tready;
  assign done = state == RX_DONE;
  assign beat = s_tvalid && s_tready;
  assign at_last = weights_received == last_idx;
  assign wr = state == RX_RECV && beat;
  // next-state decode; drain absorbs the tail of an overlong burst
  always_comb begin
    state_nx = RX_IDLE;
    case (state)
      RX_IDLE:  state_nx = cfg_valid && cfg_ok ? RX_RECV : RX_IDLE;
      RX_RECV:  state_nx = !beat ? RX_RECV : s_tlast ? RX_DONE : at_last ? RX_DRAIN : RX_RECV;
      RX_DRAIN: state_nx = beat && s_tlast ? RX_DONE : RX_DRAIN;
      RX_DONE:  state_nx = RX_IDLE;
      default:  state_nx = RX_IDLE;
    endcase
  end
  // control state, counters, error reporting and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RX_IDLE;
      wr_ptr <= '0;
      last_idx <= '0;
      weights_received <= '0;
      error <= 1'b0;
      err_code <= 2'd0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      if (state == RX_IDLE && cfg_valid) begin
        if (!cfg_ok) begin
          error <= 1'b1;
          err_code <= 2'd1;
        end else begin
          wr_ptr <= cfg_addr[ADDR_WIDTH-1:0];
          last_idx <= cfg_length - 16'd1;
          weights_received <= '0;
          error <= 1'b0;
          err_code <= 2'd0;
        end
      end
      if (wr) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        weights_received <= weights_received + 16'd1;
        if (at_last && !s_tlast) begin
          error <= 1'b1;
          err_code <= 2'd2;
        end else if (!at_last && s_tlast) begin
          error <= 1'b1;
          err_code <= 2'd3;
        end
      end
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end
  // buffer write port; contents survive reset like block RAM
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s_tdata;
  end
endmodule

// File: tb/tb_weight_stream_receiver.sv
// tb_weight_stream_receiver: table-driven burst checks with a read-data scoreboard
module tb_weight_stream_receiver;
  logic clk = 1'b0, reset = 1'b1, cfg_valid = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, rd_en = 1'b0;
  logic [15:0] cfg_addr = '0, cfg_length = '0;
  logic [7:0] s_tdata = '0;
  logic [9:0] rd_addr = '0;
  logic cfg_ready, s_tready, busy, done, error;
  logic [7:0] rd_data;
  logic [15:0] weights_received;
  logic [1:0] err_code;

  weight_stream_receiver dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_length(cfg_length), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .weights_received(weights_received), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int len; int nb; int tl; bit gap; int code; int cnt;} vec_t;
  vec_t vt [7];
  int errors = 0, checks = 0;
  logic [7:0] mm [1024];
  bit known [1024];
  logic [7:0] rdq [$];
  logic [7:0] last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    bit p;
    p = rd_en;
    @(posedge clk);
    #1;
    if (p) begin
      if (rdq.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL rd_scoreboard: got read with no expected entry");
      end else begin
        last_rd = rdq.pop_front();
        chk("rd_data", {24'd0, rd_data}, {24'd0, last_rd});
      end
    end
  endtask

  task automatic burst(input vec_t v);
    bit recv;
    recv = 1;
    cfg_valid = 1; cfg_addr = 16'(v.addr); cfg_length = 16'(v.len);
    tick();
    cfg_valid = 0;
    chk("cfg_accept_tready", s_tready, 1);
    chk("cfg_accept_cfg_ready", cfg_ready, 0);
    chk("cfg_clears_error", error, 0);
    chk("cfg_clears_count", weights_received, 0);
    for (int i = 0; i < v.nb; i++) begin
      if (v.gap) begin
        s_tvalid = 0; s_tdata = 8'hEE; s_tlast = 1; rd_en = 0;
        tick();
        chk("gap_tready", s_tready, 1);
      end
      s_tvalid = 1; s_tdata = 8'($urandom); s_tlast = (i == v.tl);
      if (v.gap && recv && known[v.addr + i]) begin
        rd_en = 1; rd_addr = 10'(v.addr + i);
        rdq.push_back(mm[v.addr + i]);
      end else rd_en = 0;
      chk("beat_tready", s_tready, 1);
      chk("no_early_done", done, 0);
      if (recv) begin
        mm[v.addr + i] = s_tdata;
        known[v.addr + i] = 1;
        if (i == v.len - 1 || s_tlast) recv = 0;
      end
      tick();
    end
    s_tvalid = 0; s_tlast = 0; rd_en = 0;
    chk("done_pulse", done, 1);
    chk("done_tready", s_tready, 0);
    chk("done_cfg_ready", cfg_ready, 0);
    chk("count", weights_received, 32'(v.cnt));
    chk("error", error, {31'd0, v.code != 0});
    chk("err_code", err_code, 32'(v.code));
    tick();
    chk("done_single", done, 0);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("count_hold", weights_received, 32'(v.cnt));
  endtask

  initial begin
    vt[0] = '{4, 3, 3, 2, 0, 0, 3};
    vt[1] = '{100, 4, 4, 3, 0, 0, 4};
    vt[2] = '{100, 4, 2, 1, 0, 3, 2};
    vt[3] = '{200, 5, 5, 4, 0, 0, 5};
    vt[4] = '{200, 2, 5, 4, 0, 2, 2};
    vt[5] = '{100, 4, 4, 3, 1, 0, 4};
    vt[6] = '{0, 1, 1, 0, 0, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_count", weights_received, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 0;
    tick();
    foreach (vt[k]) burst(vt[k]);
    cfg_valid = 1; cfg_addr = 16'd1020; cfg_length = 16'd5;
    tick();
    cfg_valid = 0;
    chk("badcfg_error", error, 1);
    chk("badcfg_code", err_code, 1);
    chk("badcfg_tready", s_tready, 0);
    chk("badcfg_cfg_ready", cfg_ready, 1);
    chk("badcfg_busy", busy, 0);
    tick();
    chk("badcfg_tready_hold", s_tready, 0);
    chk("badcfg_sticky", error, 1);
    cfg_valid = 1; cfg_addr = 16'd0; cfg_length = 16'd0;
    tick();
    cfg_valid = 0;
    chk("zerolen_code", err_code, 1);
    chk("zerolen_tready", s_tready, 0);
    burst('{1020, 4, 4, 3, 0, 0, 4});
    cfg_valid = 1; cfg_addr = 16'd300; cfg_length = 16'd8;
    tick();
    cfg_valid = 0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1; s_tdata = 8'($urandom); s_tlast = 0;
      mm[300 + i] = s_tdata;
      known[300 + i] = 1;
      tick();
    end
    s_tvalid = 0;
    chk("mid_count", weights_received, 2);
    reset = 1;
    #1;
    chk("midrst_tready", s_tready, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", weights_received, 0);
    chk("midrst_rd_data", rd_data, 0);
    tick();
    reset = 0;
    tick();
    chk("postrst_done", done, 0);
    burst('{400, 3, 3, 2, 0, 0, 3});
    for (int a = 0; a < 1024; a++) begin
      if (known[a]) begin
        rd_en = 1; rd_addr = 10'(a);
        rdq.push_back(mm[a]);
        tick();
      end
    end
    rd_en = 0;
    tick();
    chk("rd_hold", rd_data, last_rd);
    chk("rd_queue_drained", rdq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_stream_receiver.md
# weight_stream_receiver

Receive side of the accelerator's weight AXI-Stream: accepts a weight burst over a tvalid/tready/tdata/tlast slave port and writes it into a local block-RAM weight buffer at a configured base address. The compute array reads the buffer through a registered read port. The block checks burst length against tlast and reports configuration and framing errors. It sits between the weight loader's stream output and the PE weight registers.

## Interface
- DATA_WIDTH, 8, weight word width
- DEPTH, 1024, weight buffer entries
- ADDR_WIDTH, $clog2(DEPTH), read address width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cfg_valid  in  1  burst configuration strobe
- cfg_ready  out  1  high only in RX_IDLE
- cfg_addr  in  16  buffer base address of burst
- cfg_length  in  16  expected number of beats
- s_tvalid  in  1  stream beat valid
- s_tready  out  1  high in RX_RECV and RX_DRAIN
- s_tdata  in  DATA_WIDTH  weight word
- s_tlast  in  1  last beat of burst
- rd_en  in  1  buffer read enable
- rd_addr  in  ADDR_WIDTH  buffer read address
- rd_data  out  DATA_WIDTH  registered read data
- busy  out  1  high in RX_RECV or RX_DRAIN
- done  out  1  one-cycle pulse at burst end
- weights_received  out  16  beats written in current/last burst
- error  out  1  sticky until next accepted cfg
- err_code  out  2  0 none, 1 bad cfg, 2 overrun (no tlast on last expected beat), 3 short (tlast early)

## Operation
- States: RX_IDLE, RX_RECV, RX_DRAIN, RX_DONE. Illegal encoding -> RX_IDLE.
- RX_IDLE: on cfg_valid, compute cfg_addr + cfg_length at 17 bits (no wrap). If cfg_length == 0 or sum > DEPTH: error=1, err_code=1, stay RX_IDLE, nothing latched. Else latch addr/length, wr_ptr=cfg_addr, weights_received=0, error=0, err_code=0, go RX_RECV.
- RX_RECV: each beat (s_tvalid && s_tready) writes s_tdata to mem[wr_ptr], wr_ptr++, weights_received++.
  - Beat index == length-1 with s_tlast=1: go RX_DONE.
  - Beat index == length-1 with s_tlast=0: write it, error=1, err_code=2, go RX_DRAIN.
  - Beat index < length-1 with s_tlast=1: write it, error=1, err_code=3, go RX_DONE.
- RX_DRAIN: accept and discard beats (no write, no count) until a beat with s_tlast=1 is accepted, then RX_DONE.
- RX_DONE: done=1 for exactly this cycle; go RX_IDLE. cfg_valid here is ignored (cfg_ready=0).
- Read port: rd_en samples mem[rd_addr] into rd_data; rd_data holds when rd_en=0. Same-cycle read and write to same address returns old data (read-first).
- Buffer contents are not cleared by reset (block RAM); only control state is.

## Timing
- Reset values: state RX_IDLE, cfg_ready=1, s_tready=0, busy=0, done=0, error=0, err_code=0, weights_received=0, rd_data=0.
- cfg accepted at edge N -> s_tready=1 from cycle N+1.
- s_tready is a pure state decode; does not depend on s_tvalid. Full-rate: one beat per cycle.
- Final beat accepted at edge M -> done=1 and s_tready=0 in cycle M+1, cfg_ready=1 in cycle M+2.
- weights_received updates the cycle after each written beat; holds after done until next accepted cfg.
- rd_data latency: 1 cycle after rd_en edge.
- Reset asserted mid-burst: immediately RX_IDLE, s_tready=0, partial writes remain in buffer, no done pulse.

## Test plan
- cfg addr=4, length=3; stream 0x11,0x22,0x33 with tlast on third, continuous tvalid -> done pulses once, weights_received=3, error=0; reads of 4,5,6 return 0x11,0x22,0x33 one cycle after rd_en.
- cfg addr=1020, length=5 (DEPTH=1024) -> error=1, err_code=1, s_tready stays 0, cfg_ready stays 1; then cfg addr=1020, length=4 accepted, error clears.
- cfg length=4; tlast on beat 2 -> err_code=3, weights_received=2, done pulses, entries addr+2..addr+3 unchanged.
- cfg length=2; send 5 beats, tlast on 5th -> err_code=2, weights_received=2, beats 3-5 not written, done after 5th beat.
- cfg length=4 with tvalid toggling every other cycle and rd_en reading addr during write of addr -> only handshaken beats written, read returns prior value.
- Assert reset after 2 of 8 beats -> outputs at reset values next cycle, new cfg accepted normally afterward.
